// File: rtl/reg_file_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. load returns,
// with an in-order load FIFO, busy scoreboard and starvation drain.
module reg_file_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    w_pipe_wen,
    input  logic [ADDR_W-1:0]       w_pipe_waddr,
    input  logic [DATA_W-1:0]       w_pipe_wdata,
    input  logic                    w_ld_valid,
    input  logic [ADDR_W-1:0]       w_ld_waddr,
    input  logic [DATA_W-1:0]       w_ld_wdata,
    output logic                    w_ld_ready,
    input  logic                    w_ld_issue,
    input  logic [ADDR_W-1:0]       w_ld_issue_addr,
    input  logic [ADDR_W-1:0]       w_rs_addr,
    input  logic [ADDR_W-1:0]       w_rt_addr,
    output logic                    w_rs_busy,
    output logic                    w_rt_busy,
    output logic                    w_pipe_stall,
    output logic                    w_rf_wen,
    output logic [ADDR_W-1:0]       w_rf_waddr,
    output logic [DATA_W-1:0]       w_rf_wdata,
    output logic [$clog2(DEPTH):0]  w_fifo_count,
    output logic                    w_waw_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SV_W  = $clog2(STARVE_MAX + 1);
    localparam int NREG  = 1 << ADDR_W;

    typedef enum logic {ARB, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [SV_W-1:0]   starve_q, starve_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_d_q [DEPTH];
    logic [NREG-1:0]   sb_q, sb_d;
    logic              rf_wen_q, rf_wen_d;
    logic              rf_ld_q, rf_ld_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_q, err_d;

    logic pipe_req, ld_req, fifo_empty, enq, deq;

    assign w_ld_ready   = (cnt_q != CNT_W'(DEPTH));
    assign w_pipe_stall = (state_q == DRAIN);
    assign w_rf_wen     = rf_wen_q;
    assign w_rf_waddr   = rf_waddr_q;
    assign w_rf_wdata   = rf_wdata_q;
    assign w_fifo_count = cnt_q;
    assign w_waw_err    = err_q;
    assign w_rs_busy    = (w_rs_addr != '0) && sb_q[w_rs_addr];
    assign w_rt_busy    = (w_rt_addr != '0) && sb_q[w_rt_addr];

    assign pipe_req   = w_pipe_wen && (w_pipe_waddr != '0);
    assign ld_req     = w_ld_valid && w_ld_ready && (w_ld_waddr != '0);
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        state_d    = ARB;
        starve_d   = starve_q;
        rf_wen_d   = 1'b0;
        rf_ld_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        enq        = 1'b0;
        deq        = 1'b0;
        err_d      = err_q | (w_ld_valid & ~w_ld_ready);
        unique case (state_q)
            DRAIN: begin
                deq      = !fifo_empty;
                enq      = ld_req;
                starve_d = '0;
            end
            ARB: begin
                if (pipe_req) begin
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = w_pipe_waddr;
                    rf_wdata_d = w_pipe_wdata;
                    enq        = ld_req;
                    if (sb_q[w_pipe_waddr]) err_d = 1'b1;
                    starve_d = fifo_empty ? '0 : starve_q + 1'b1;
                end else if (!fifo_empty) begin
                    deq      = 1'b1;
                    enq      = ld_req;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                    if (ld_req) begin
                        rf_wen_d   = 1'b1;
                        rf_ld_d    = 1'b1;
                        rf_waddr_d = w_ld_waddr;
                        rf_wdata_d = w_ld_wdata;
                    end
                end
                if (starve_d == SV_W'(STARVE_MAX)) state_d = DRAIN;
            end
            default: ;
        endcase
        if (deq) begin
            rf_wen_d   = 1'b1;
            rf_ld_d    = 1'b1;
            rf_waddr_d = mem_a_q[rd_q];
            rf_wdata_d = mem_d_q[rd_q];
        end
    end

    always_comb begin
        rd_d  = deq ? rd_q + 1'b1 : rd_q;
        wr_d  = enq ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q;
        if (enq && !deq) cnt_d = cnt_q + 1'b1;
        if (!enq && deq) cnt_d = cnt_q - 1'b1;
    end

    // Set after clear so a re-issue in the clearing cycle stays busy.
    always_comb begin
        sb_d = sb_q;
        if (rf_wen_q && rf_ld_q) sb_d[rf_waddr_q] = 1'b0;
        if (w_ld_issue && (w_ld_issue_addr != '0))
            sb_d[w_ld_issue_addr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ARB;
            starve_q   <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            sb_q       <= '0;
            rf_wen_q   <= 1'b0;
            rf_ld_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            sb_q       <= sb_d;
            rf_wen_q   <= rf_wen_d;
            rf_ld_q    <= rf_ld_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem_a_q[wr_q] <= w_ld_waddr;
            mem_d_q[wr_q] <= w_ld_wdata;
        end
    end
endmodule
